// File: rtl/data_pack_pkg.sv
// rtl/data_pack_pkg.sv - shared constants and FSM state type for the 7-to-32 bit packer
package data_pack_pkg;

  localparam int IN_W  = 7;
  localparam int OUT_W = 32;
  localparam int ACC_W = 38;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE,
    PKT,
    FLUSH
  } state_e;

endpackage

// File: rtl/data_pack_if.sv
// rtl/data_pack_if.sv - value-in / word-out handshake bundle for data_pack
interface data_pack_if;
  import data_pack_pkg::*;

  logic             ready_out;
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             sop_in;
  logic             eop_in;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
  logic             ready_in;

  modport slave (
    output ready_out,
    input  valid_in, data_in, sop_in, eop_in,
    output valid_out, data_out, sop_out, eop_out,
    input  ready_in
  );

  modport master (
    input  ready_out,
    output valid_in, data_in, sop_in, eop_in,
    input  valid_out, data_out, sop_out, eop_out,
    output ready_in
  );

endinterface

// File: rtl/data_pack_datapath.sv
// rtl/data_pack_datapath.sv - bit accumulator: inserts values at cnt, shifts out whole words
module data_pack_datapath
  import data_pack_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [IN_W-1:0]  data_in,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic [OUT_W-1:0] ins_word,
  output logic [OUT_W-1:0] res_word
);

  logic [ACC_W-1:0] acc_q, acc_d, ins;
  logic [CNT_W-1:0] cnt_q, cnt_d, n;

  // Bits at and above cnt are always zero, so OR-insert is exact and the
  // low word of a short accumulator is already zero-padded.
  always_comb begin
    ins   = acc_q | (ACC_W'(data_in) << cnt_q);
    n     = cnt_q + CNT_W'(IN_W);
    full  = (n >= CNT_W'(OUT_W));
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load) begin
      if (full) begin
        acc_d = ins >> OUT_W;
        cnt_d = n - CNT_W'(OUT_W);
      end else begin
        acc_d = ins;
        cnt_d = n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign ins_word = ins[OUT_W-1:0];
  assign res_word = acc_q[OUT_W-1:0];

endmodule

// File: rtl/data_pack.sv
// rtl/data_pack.sv - packs framed 7-bit values LSB-first into framed 32-bit words
module data_pack
  import data_pack_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  data_pack_if.slave bus
);

  state_e           state_q, state_d;
  logic             sop_pend_q, sop_pend_d;
  logic             valid_q, valid_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic             sop_q, sop_d;
  logic             eop_q, eop_d;

  logic             out_free, ready, take, pend;
  logic             load, clear, emit, emit_sop, emit_eop;
  logic [OUT_W-1:0] emit_data;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic [OUT_W-1:0] ins_word, res_word;

  data_pack_datapath u_datapath (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .clear    (clear),
    .data_in  (bus.data_in),
    .cnt      (cnt),
    .full     (full),
    .ins_word (ins_word),
    .res_word (res_word)
  );

  always_comb begin
    out_free   = !valid_q || bus.ready_in;
    state_d    = state_q;
    sop_pend_d = sop_pend_q;
    ready      = 1'b0;
    take       = 1'b0;
    pend       = sop_pend_q;
    load       = 1'b0;
    clear      = 1'b0;
    emit       = 1'b0;
    emit_data  = ins_word;
    emit_sop   = 1'b0;
    emit_eop   = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        take  = bus.valid_in && bus.sop_in;
        pend  = 1'b1;
      end
      PKT: begin
        // A value that completes a word needs the output slot; one that does not can always go in.
        ready = out_free || !full;
        take  = bus.valid_in && ready;
      end
      FLUSH: begin
        if (out_free) begin
          emit       = 1'b1;
          emit_data  = res_word;
          emit_sop   = sop_pend_q;
          emit_eop   = 1'b1;
          clear      = 1'b1;
          sop_pend_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      if (full) begin
        emit       = 1'b1;
        emit_sop   = pend;
        emit_eop   = bus.eop_in && (cnt == CNT_W'(OUT_W - IN_W));
        load       = 1'b1;
        sop_pend_d = 1'b0;
        if (!bus.eop_in)  state_d = PKT;
        else if (emit_eop) state_d = IDLE;
        else              state_d = FLUSH;
      end else if (bus.eop_in && out_free) begin
        emit       = 1'b1;
        emit_sop   = pend;
        emit_eop   = 1'b1;
        clear      = 1'b1;
        sop_pend_d = 1'b0;
        state_d    = IDLE;
      end else begin
        load       = 1'b1;
        sop_pend_d = pend;
        state_d    = bus.eop_in ? FLUSH : PKT;
      end
    end

    valid_d = valid_q;
    data_d  = data_q;
    sop_d   = sop_q;
    eop_d   = eop_q;
    if (emit) begin
      valid_d = 1'b1;
      data_d  = emit_data;
      sop_d   = emit_sop;
      eop_d   = emit_eop;
    end else if (bus.ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sop_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sop_pend_q <= sop_pend_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
    end
  end

  assign bus.ready_out = ready;
  assign bus.valid_out = valid_q;
  assign bus.data_out  = data_q;
  assign bus.sop_out   = sop_q;
  assign bus.eop_out   = eop_q;

endmodule
